// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction ROM
// and captures the returned word into the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_PC   = 32'h8000_0004,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  input  logic        illop,
  input  logic        irq,
  output logic        ifid_valid,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        exc_taken,
  output logic [31:0] exc_epc
);

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ifid_t;

  typedef enum logic [2:0] {
    SRC_BRANCH,
    SRC_ILLOP,
    SRC_JUMP,
    SRC_IRQ,
    SRC_STALL,
    SRC_SEQ
  } src_e;

  logic [31:0] pc, pc_next, pc_seq;
  ifid_t       ifid, ifid_next;
  logic        exc_next;
  logic [31:0] epc_next;
  src_e        src;

  assign pc_seq    = pc + 32'd4;
  assign imem_addr = pc;

  // Priority arbitration; illop and jump only count for a real instruction in IF/ID,
  // and interrupts are masked while running supervisor code (PC[31] set).
  always_comb begin
    if (branch_taken)                      src = SRC_BRANCH;
    else if (illop && ifid.valid)          src = SRC_ILLOP;
    else if (jump_taken && ifid.valid)     src = SRC_JUMP;
    else if (irq && !pc[31] && !stall)     src = SRC_IRQ;
    else if (stall)                        src = SRC_STALL;
    else                                   src = SRC_SEQ;
  end

  // NOTE: every output of this block is given a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    pc_next   = pc;
    ifid_next = ifid;
    exc_next  = 1'b0;
    epc_next  = exc_epc;
    case (src)
      SRC_BRANCH: begin
        pc_next         = branch_target;
        ifid_next.valid = 1'b0;
        ifid_next.inst  = '0;
      end
      SRC_ILLOP: begin
        pc_next         = ILLOP_PC;
        ifid_next.valid = 1'b0;
        ifid_next.inst  = '0;
        exc_next        = 1'b1;
        epc_next        = ifid.pc4;
      end
      SRC_JUMP: begin
        pc_next         = jump_target;
        ifid_next.valid = 1'b0;
        ifid_next.inst  = '0;
      end
      SRC_IRQ: begin
        // The fetched word is dropped; the handler returns to epc-4 to re-execute it.
        pc_next         = IRQ_PC;
        ifid_next.valid = 1'b0;
        ifid_next.inst  = '0;
        exc_next        = 1'b1;
        epc_next        = pc_seq;
      end
      SRC_STALL: begin
        pc_next   = pc;
        ifid_next = ifid;
      end
      default: begin
        pc_next   = pc_seq;
        ifid_next = '{valid: 1'b1, inst: imem_data, pc: pc, pc4: pc_seq};
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      ifid      <= '0;
      exc_taken <= 1'b0;
      exc_epc   <= '0;
    end else begin
      pc        <= pc_next;
      ifid      <= ifid_next;
      exc_taken <= exc_next;
      exc_epc   <= epc_next;
    end
  end

  assign ifid_valid = ifid.valid;
  assign ifid_inst  = ifid.inst;
  assign ifid_pc    = ifid.pc;
  assign ifid_pc4   = ifid.pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stimulus pushes cycle-tagged expected
// outputs; a monitor pops and compares them on the falling edge.
module tb_fetch_stage;

  typedef enum int {S_ADDR, S_VALID, S_INST, S_PC, S_PC4, S_EXC, S_EPC} sig_e;

  typedef struct {
    int          cyc;
    string       name;
    sig_e        sel;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_data;
  logic        stall, branch_taken, jump_taken, illop, irq;
  logic [31:0] branch_target, jump_target;
  logic        ifid_valid, exc_taken;
  logic [31:0] ifid_inst, ifid_pc, ifid_pc4, exc_epc;

  int   cyc = 0;
  int   vectors = 0;
  int   fails = 0;
  exp_t sb[$];

  fetch_stage dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_taken(jump_taken), .jump_target(jump_target),
    .illop(illop), .irq(irq),
    .ifid_valid(ifid_valid), .ifid_inst(ifid_inst),
    .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .exc_taken(exc_taken), .exc_epc(exc_epc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h8000_000C) return 32'h3c08_4000;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  assign imem_data = rom_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every expectation tagged with the current cycle.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        case (e.sel)
          S_ADDR:  act = imem_addr;
          S_VALID: act = {31'b0, ifid_valid};
          S_INST:  act = ifid_inst;
          S_PC:    act = ifid_pc;
          S_PC4:   act = ifid_pc4;
          S_EXC:   act = {31'b0, exc_taken};
          default: act = exc_epc;
        endcase
        if (e.cyc != cyc) check({e.name, "_late"}, 32'(e.cyc), 32'(cyc));
        else              check(e.name, act, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_sig(input string n, input sig_e s, input logic [31:0] v);
    sb.push_back('{cyc, n, s, v});
  endtask

  task automatic exp_ifid(input string n, input logic v, input logic [31:0] inst,
                          input logic [31:0] pc, input logic [31:0] pc4);
    exp_sig({n, "_valid"}, S_VALID, {31'b0, v});
    exp_sig({n, "_inst"},  S_INST,  inst);
    exp_sig({n, "_pc"},    S_PC,    pc);
    exp_sig({n, "_pc4"},   S_PC4,   pc4);
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump_taken = 0; illop = 0; irq = 0;
    branch_target = '0; jump_target = '0;
  endtask

  task automatic branch(input logic [31:0] t);
    branch_taken = 1; branch_target = t;
  endtask

  initial begin
    idle();
    reset = 1;
    step();
    exp_sig("rst_addr", S_ADDR, 32'h8000_0000);
    exp_ifid("rst", 1'b0, 32'h0, 32'h0, 32'h0);
    exp_sig("rst_exc", S_EXC, 32'h0);
    exp_sig("rst_epc", S_EPC, 32'h0);
    step();
    reset = 0;
    exp_sig("boot_addr0", S_ADDR, 32'h8000_0000);

    // Free-running fetch from the reset vector
    step(); exp_sig("seq_addr1", S_ADDR, 32'h8000_0004);
    exp_ifid("seq1", 1'b1, 32'hDA5A_5A5A, 32'h8000_0000, 32'h8000_0004);
    step(); exp_sig("seq_addr2", S_ADDR, 32'h8000_0008);
    step(); exp_sig("seq_addr3", S_ADDR, 32'h8000_000C);
    step(); exp_sig("seq_addr4", S_ADDR, 32'h8000_0010);
    exp_ifid("seq4", 1'b1, 32'h3c08_4000, 32'h8000_000C, 32'h8000_0010);
    exp_sig("seq4_exc", S_EXC, 32'h0);

    // Jump with a valid IF/ID, then a jump ignored because IF/ID is a bubble
    branch(32'h8000_0000); step();
    exp_sig("br0_addr", S_ADDR, 32'h8000_0000);
    exp_ifid("br0", 1'b0, 32'h0, 32'h8000_000C, 32'h8000_0010);
    idle(); step();
    exp_ifid("pre_jmp", 1'b1, 32'hDA5A_5A5A, 32'h8000_0000, 32'h8000_0004);
    jump_taken = 1; jump_target = 32'h8000_000C; step();
    exp_sig("jmp_addr", S_ADDR, 32'h8000_000C);
    exp_ifid("jmp", 1'b0, 32'h0, 32'h8000_0000, 32'h8000_0004);
    exp_sig("jmp_exc", S_EXC, 32'h0);
    jump_target = 32'h8000_0100; step();
    exp_sig("jmp_bub_addr", S_ADDR, 32'h8000_0010);
    exp_ifid("jmp_bub", 1'b1, 32'h3c08_4000, 32'h8000_000C, 32'h8000_0010);

    // Illegal op: taken with valid IF/ID, ignored on the following bubble
    idle(); illop = 1; step();
    exp_sig("ill_addr", S_ADDR, 32'h8000_0008);
    exp_sig("ill_valid", S_VALID, 32'h0);
    exp_sig("ill_exc", S_EXC, 32'h1);
    exp_sig("ill_epc", S_EPC, 32'h8000_0010);
    step();
    exp_sig("ill_bub_addr", S_ADDR, 32'h8000_000C);
    exp_ifid("ill_bub", 1'b1, 32'hDA5A_5A52, 32'h8000_0008, 32'h8000_000C);
    exp_sig("ill_bub_exc", S_EXC, 32'h0);
    exp_sig("ill_bub_epc", S_EPC, 32'h8000_0010);

    // Interrupt from user code, then masked in handler code
    idle(); branch(32'h0000_0040); step();
    exp_sig("br40_addr", S_ADDR, 32'h0000_0040);
    idle(); irq = 1; step();
    exp_sig("irq_addr", S_ADDR, 32'h8000_0004);
    exp_sig("irq_exc", S_EXC, 32'h1);
    exp_sig("irq_epc", S_EPC, 32'h0000_0044);
    exp_sig("irq_valid", S_VALID, 32'h0);
    step();
    exp_sig("irq_mask_addr", S_ADDR, 32'h8000_0008);
    exp_sig("irq_pulse_end", S_EXC, 32'h0);
    exp_ifid("irq_mask", 1'b1, 32'hDA5A_5A5E, 32'h8000_0004, 32'h8000_0008);
    branch(32'h8000_0070); step();
    exp_sig("br70_addr", S_ADDR, 32'h8000_0070);
    exp_sig("br70_exc", S_EXC, 32'h0);
    branch_taken = 0; step();
    exp_sig("irq_k_addr", S_ADDR, 32'h8000_0074);
    exp_sig("irq_k_exc", S_EXC, 32'h0);

    // Adder wrap into user space, irq held off by stall, then taken
    idle(); branch(32'hFFFF_FFFC); step();
    exp_sig("brfc_addr", S_ADDR, 32'hFFFF_FFFC);
    idle(); step();
    exp_sig("wrap_addr", S_ADDR, 32'h0000_0000);
    exp_ifid("wrap", 1'b1, 32'hA5A5_A5A6, 32'hFFFF_FFFC, 32'h0000_0000);
    stall = 1; irq = 1; step();
    exp_sig("irq_stall_addr", S_ADDR, 32'h0000_0000);
    exp_sig("irq_stall_exc", S_EXC, 32'h0);
    exp_sig("irq_stall_pc", S_PC, 32'hFFFF_FFFC);
    stall = 0; step();
    exp_sig("irq2_addr", S_ADDR, 32'h8000_0004);
    exp_sig("irq2_exc", S_EXC, 32'h1);
    exp_sig("irq2_epc", S_EPC, 32'h0000_0004);

    // Stall holds PC and IF/ID; branch overrides stall
    idle(); branch(32'h0000_001C); step();
    idle(); step();
    exp_sig("pre_stall_addr", S_ADDR, 32'h0000_0020);
    exp_ifid("pre_stall", 1'b1, 32'h5A5A_5A46, 32'h0000_001C, 32'h0000_0020);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_sig($sformatf("stall%0d_addr", i), S_ADDR, 32'h0000_0020);
      exp_ifid($sformatf("stall%0d", i), 1'b1, 32'h5A5A_5A46, 32'h0000_001C, 32'h0000_0020);
    end
    branch(32'h0000_0100); step();
    exp_sig("stall_br_addr", S_ADDR, 32'h0000_0100);
    exp_ifid("stall_br", 1'b0, 32'h0, 32'h0000_001C, 32'h0000_0020);

    // Everything at once: branch wins; then illop beats jump and irq
    idle(); step();
    exp_ifid("pre_all", 1'b1, 32'h5A5A_5B5A, 32'h0000_0100, 32'h0000_0104);
    branch(32'h0000_0200); jump_taken = 1; jump_target = 32'h0000_0300;
    illop = 1; irq = 1; step();
    exp_sig("all_addr", S_ADDR, 32'h0000_0200);
    exp_sig("all_exc", S_EXC, 32'h0);
    exp_sig("all_valid", S_VALID, 32'h0);
    idle(); step();
    exp_sig("pre_ill2_addr", S_ADDR, 32'h0000_0204);
    illop = 1; jump_taken = 1; jump_target = 32'h0000_0300; irq = 1; step();
    exp_sig("ill2_addr", S_ADDR, 32'h8000_0008);
    exp_sig("ill2_exc", S_EXC, 32'h1);
    exp_sig("ill2_epc", S_EPC, 32'h0000_0204);
    idle(); step();
    exp_sig("post_ill2_addr", S_ADDR, 32'h8000_000C);
    exp_sig("post_ill2_epc", S_EPC, 32'h0000_0204);

    // Asynchronous reset mid-cycle with a branch pending
    @(negedge clk); #1;
    branch(32'h0000_0400);
    #1 reset = 1;
    #1;
    check("async_addr", imem_addr, 32'h8000_0000);
    check("async_valid", {31'b0, ifid_valid}, 32'h0);
    check("async_inst", ifid_inst, 32'h0);
    check("async_pc", ifid_pc, 32'h0);
    check("async_pc4", ifid_pc4, 32'h0);
    check("async_exc", {31'b0, exc_taken}, 32'h0);
    check("async_epc", exc_epc, 32'h0);
    step();
    exp_sig("rst_hold_addr", S_ADDR, 32'h8000_0000);
    idle(); reset = 0;
    exp_sig("rel_addr", S_ADDR, 32'h8000_0000);
    step();
    exp_sig("rel_seq_addr", S_ADDR, 32'h8000_0004);
    exp_ifid("rel_seq", 1'b1, 32'hDA5A_5A5A, 32'h8000_0000, 32'h8000_0004);

    step();
    step();
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
